// File: rtl/riscv_rf_pkg.sv
// Shared constants and types for the integer register-file write path.
package riscv_rf_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 2 ** ADDR_W;

  // Which producer owns the write port in a given cycle.
  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_WB,
    SRC_MC
  } wr_src_e;

  // One buffered multi-cycle result.
  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } rf_entry_t;

endpackage

// File: rtl/regfile_wr_arbiter_if.sv
// Bundle of WB, multi-cycle, hazard-check and register-file write signals.
interface regfile_wr_arbiter_if #(
  parameter int DATA_W     = riscv_rf_pkg::DATA_W,
  parameter int ADDR_W     = riscv_rf_pkg::ADDR_W,
  parameter int FIFO_DEPTH = 2
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic                   wb_regwrite;
  logic [ADDR_W-1:0]      wb_rd;
  logic [DATA_W-1:0]      wb_data;
  logic                   mc_valid;
  logic                   mc_ready;
  logic [ADDR_W-1:0]      mc_rd;
  logic [DATA_W-1:0]      mc_data;
  logic                   issue_valid;
  logic [ADDR_W-1:0]      issue_rd;
  logic [ADDR_W-1:0]      chk_rs1;
  logic [ADDR_W-1:0]      chk_rs2;
  logic [ADDR_W-1:0]      chk_rd;
  logic                   stall;
  logic                   rf_regwrite;
  logic [ADDR_W-1:0]      rf_rd;
  logic [DATA_W-1:0]      rf_write_data;
  logic [CNT_W-1:0]       fifo_count;
  logic [2**ADDR_W-1:0]   busy_mask;

  // Pipeline / execution-unit side.
  modport master (
    output wb_regwrite, wb_rd, wb_data,
    output mc_valid, mc_rd, mc_data,
    output issue_valid, issue_rd,
    output chk_rs1, chk_rs2, chk_rd,
    input  mc_ready, stall,
    input  rf_regwrite, rf_rd, rf_write_data,
    input  fifo_count, busy_mask
  );

  // Arbiter side.
  modport slave (
    input  wb_regwrite, wb_rd, wb_data,
    input  mc_valid, mc_rd, mc_data,
    input  issue_valid, issue_rd,
    input  chk_rs1, chk_rs2, chk_rd,
    output mc_ready, stall,
    output rf_regwrite, rf_rd, rf_write_data,
    output fifo_count, busy_mask
  );

endinterface

// File: rtl/rf_wr_fifo.sv
// Small synchronous FIFO for multi-cycle results; DEPTH must be a power of two.
module rf_wr_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Entry storage, written on push.
  // NOTE: the data array has no reset; occupancy is tracked by count, so stale entries are never read.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two; count tracks occupancy.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Register-file write-port arbiter: WB has fixed priority, multi-cycle results
// are buffered and drained in order, and a busy scoreboard drives decode stalls.
module regfile_wr_arbiter
  import riscv_rf_pkg::wr_src_e, riscv_rf_pkg::SRC_NONE, riscv_rf_pkg::SRC_WB, riscv_rf_pkg::SRC_MC;
#(
  parameter int DATA_W     = riscv_rf_pkg::DATA_W,
  parameter int ADDR_W     = riscv_rf_pkg::ADDR_W,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  regfile_wr_arbiter_if.slave  bus
);

  localparam int NUM_REGS = 2 ** ADDR_W;
  localparam int CNT_W    = $clog2(FIFO_DEPTH) + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t              fifo_in;
  entry_t              fifo_head;
  logic                fifo_push;
  logic                fifo_pop;
  logic                fifo_full;
  logic                fifo_empty;
  logic [CNT_W-1:0]    fifo_count;

  logic                wb_sel;
  logic                mc_accept;
  logic                mc_keep;
  wr_src_e             src;
  logic [ADDR_W-1:0]   sel_rd;
  logic [DATA_W-1:0]   sel_data;

  logic                rf_regwrite_q;
  logic [ADDR_W-1:0]   rf_rd_q;
  logic [DATA_W-1:0]   rf_data_q;
  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] busy_nxt;

  // Writes to x0 are dropped here, on both inputs.
  assign wb_sel    = bus.wb_regwrite && (bus.wb_rd != '0);
  assign mc_accept = bus.mc_valid && !fifo_full;
  assign mc_keep   = mc_accept && (bus.mc_rd != '0);
  assign fifo_in   = '{rd: bus.mc_rd, data: bus.mc_data};

  rf_wr_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(entry_t))
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (fifo_in),
    .rdata (fifo_head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Choose the write-port owner: WB, else FIFO head, else bypass of a fresh result.
  // NOTE: every output gets a default first so no path through the block infers a latch.
  always_comb begin
    src       = SRC_NONE;
    sel_rd    = fifo_head.rd;
    sel_data  = fifo_head.data;
    fifo_pop  = 1'b0;
    fifo_push = mc_keep;
    if (wb_sel) begin
      src      = SRC_WB;
      sel_rd   = bus.wb_rd;
      sel_data = bus.wb_data;
    end else if (!fifo_empty) begin
      src      = SRC_MC;
      fifo_pop = 1'b1;
    end else if (mc_keep) begin
      src       = SRC_MC;
      sel_rd    = bus.mc_rd;
      sel_data  = bus.mc_data;
      fifo_push = 1'b0;
    end
  end

  // Registered write port; address and data hold when nothing is selected.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rf_regwrite_q <= 1'b0;
      rf_rd_q       <= '0;
      rf_data_q     <= '0;
    end else begin
      rf_regwrite_q <= (src != SRC_NONE);
      if (src != SRC_NONE) begin
        rf_rd_q   <= sel_rd;
        rf_data_q <= sel_data;
      end
    end
  end

  // Scoreboard update: an MC write clears its register, a new issue sets one (set wins).
  always_comb begin
    busy_nxt = busy;
    if (src == SRC_MC) busy_nxt[sel_rd] = 1'b0;
    if (bus.issue_valid && (bus.issue_rd != '0)) busy_nxt[bus.issue_rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy <= '0;
    end else begin
      busy <= busy_nxt;
    end
  end

  assign bus.mc_ready      = !fifo_full;
  assign bus.fifo_count    = fifo_count;
  assign bus.busy_mask     = busy;
  assign bus.rf_regwrite   = rf_regwrite_q;
  assign bus.rf_rd         = rf_rd_q;
  assign bus.rf_write_data = rf_data_q;
  assign bus.stall = (busy[bus.chk_rs1] && (bus.chk_rs1 != '0)) ||
                     (busy[bus.chk_rs2] && (bus.chk_rs2 != '0)) ||
                     (busy[bus.chk_rd]  && (bus.chk_rd  != '0));

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Self-checking bench for regfile_wr_arbiter: directed vector table, a mid-operation
// reset sequence, and random traffic checked against a queue-based reference model.
module tb_regfile_wr_arbiter;
  import riscv_rf_pkg::*;

  localparam int DEPTH = 2;

  typedef struct {
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        mc_valid;
    logic [4:0]  mc_rd;
    logic [31:0] mc_data;
    logic        iss;
    logic [4:0]  iss_rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
  } stim_t;

  typedef struct {
    stim_t       s;
    logic        ready;
    logic        stall;
    logic        we;
    logic [4:0]  rd;
    logic [31:0] data;
    int          cnt;
    logic [31:0] busy;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  regfile_wr_arbiter_if #(.FIFO_DEPTH(DEPTH)) bus ();

  regfile_wr_arbiter #(.FIFO_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: results in acceptance order, busy bits, expected write port.
  rf_entry_t   mq[$];
  logic [31:0] m_busy;
  logic        m_we;
  logic [4:0]  m_rd;
  logic [31:0] m_data;

  vec_t vt[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic stim_t st(input logic wb_we, input logic [4:0] wb_rd, input logic [31:0] wb_data,
                               input logic mcv, input logic [4:0] mc_rd, input logic [31:0] mc_data,
                               input logic iss, input logic [4:0] iss_rd,
                               input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd);
    stim_t s;
    s.wb_we = wb_we; s.wb_rd = wb_rd; s.wb_data = wb_data;
    s.mc_valid = mcv; s.mc_rd = mc_rd; s.mc_data = mc_data;
    s.iss = iss; s.iss_rd = iss_rd;
    s.rs1 = rs1; s.rs2 = rs2; s.rd = rd;
    return s;
  endfunction

  function automatic stim_t idle();
    return st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  function automatic void add(input stim_t s, input logic ready, input logic stall, input logic we,
                              input logic [4:0] rd, input logic [31:0] data, input int cnt,
                              input logic [31:0] busy);
    vec_t v;
    v.s = s; v.ready = ready; v.stall = stall; v.we = we;
    v.rd = rd; v.data = data; v.cnt = cnt; v.busy = busy;
    vt.push_back(v);
  endfunction

  function automatic void reset_model();
    mq.delete();
    m_busy = '0;
    m_we   = 1'b0;
    m_rd   = '0;
    m_data = '0;
  endfunction

  // One clock of the arbiter as described in words: ready/stall from current state,
  // then WB > oldest buffered result > fresh result, then enqueue, then scoreboard.
  function automatic void model_step(input stim_t s, output logic ready, output logic stall);
    rf_entry_t e;
    logic      keep;
    ready = (mq.size() < DEPTH);
    stall = (s.rs1 != 0 && m_busy[s.rs1]) || (s.rs2 != 0 && m_busy[s.rs2]) ||
            (s.rd != 0 && m_busy[s.rd]);
    keep = s.mc_valid && ready && (s.mc_rd != 0);
    if (s.wb_we && s.wb_rd != 0) begin
      m_we = 1'b1; m_rd = s.wb_rd; m_data = s.wb_data;
    end else if (mq.size() > 0) begin
      e = mq.pop_front();
      m_we = 1'b1; m_rd = e.rd; m_data = e.data;
      m_busy[e.rd] = 1'b0;
    end else if (keep) begin
      m_we = 1'b1; m_rd = s.mc_rd; m_data = s.mc_data;
      m_busy[s.mc_rd] = 1'b0;
      keep = 1'b0;
    end else begin
      m_we = 1'b0;
    end
    if (keep) mq.push_back('{rd: s.mc_rd, data: s.mc_data});
    assert (!(s.iss && s.iss_rd != 0 && m_busy[s.iss_rd]))
      else $error("illegal issue to busy register x%0d", s.iss_rd);
    if (s.iss && s.iss_rd != 0) m_busy[s.iss_rd] = 1'b1;
  endfunction

  task automatic drive(input stim_t s);
    bus.wb_regwrite = s.wb_we;
    bus.wb_rd       = s.wb_rd;
    bus.wb_data     = s.wb_data;
    bus.mc_valid    = s.mc_valid;
    bus.mc_rd       = s.mc_rd;
    bus.mc_data     = s.mc_data;
    bus.issue_valid = s.iss;
    bus.issue_rd    = s.iss_rd;
    bus.chk_rs1     = s.rs1;
    bus.chk_rs2     = s.rs2;
    bus.chk_rd      = s.rd;
  endtask

  // Apply one table vector (call between posedge and negedge); compare with its hand values.
  task automatic step_tab(input int i, input vec_t v);
    logic er, es;
    drive(v.s);
    @(negedge clk);
    check($sformatf("v%0d mc_ready", i), bus.mc_ready, v.ready);
    check($sformatf("v%0d stall", i), bus.stall, v.stall);
    model_step(v.s, er, es);
    @(posedge clk);
    #1;
    check($sformatf("v%0d rf_regwrite", i), bus.rf_regwrite, v.we);
    check($sformatf("v%0d rf_rd", i), bus.rf_rd, v.rd);
    check($sformatf("v%0d rf_write_data", i), bus.rf_write_data, v.data);
    check($sformatf("v%0d fifo_count", i), bus.fifo_count, v.cnt);
    check($sformatf("v%0d busy_mask", i), bus.busy_mask, v.busy);
  endtask

  // Apply one cycle and compare against the reference model.
  task automatic step_model(input string tag, input stim_t s);
    logic er, es;
    drive(s);
    @(negedge clk);
    model_step(s, er, es);
    check({tag, " mc_ready"}, bus.mc_ready, er);
    check({tag, " stall"}, bus.stall, es);
    @(posedge clk);
    #1;
    check({tag, " rf_regwrite"}, bus.rf_regwrite, m_we);
    check({tag, " rf_rd"}, bus.rf_rd, m_rd);
    check({tag, " rf_write_data"}, bus.rf_write_data, m_data);
    check({tag, " fifo_count"}, bus.fifo_count, mq.size());
    check({tag, " busy_mask"}, bus.busy_mask, m_busy);
  endtask

  function automatic logic [4:0] pick_busy();
    int start;
    int r;
    start = $urandom_range(0, 30);
    for (int k = 0; k < 31; k++) begin
      r = 1 + (start + k) % 31;
      if (m_busy[r]) return 5'(r);
    end
    return 5'($urandom_range(0, 31));
  endfunction

  initial begin
    stim_t s;
    stim_t last;
    logic  hold;
    logic [4:0] r;

    // ---------------- reset state ----------------
    reset = 1'b0;
    drive(idle());
    reset_model();
    #1;
    check("reset rf_regwrite", bus.rf_regwrite, 0);
    check("reset rf_rd", bus.rf_rd, 0);
    check("reset rf_write_data", bus.rf_write_data, 0);
    check("reset fifo_count", bus.fifo_count, 0);
    check("reset busy_mask", bus.busy_mask, 0);
    check("reset mc_ready", bus.mc_ready, 1);
    check("reset stall", bus.stall, 0);
    #16;
    reset = 1'b1;

    // ---------------- directed vector table ----------------
    //  st(wb_we,wb_rd,wb_data, mcv,mc_rd,mc_data, iss,iss_rd, rs1,rs2,rd)  ready stall we rd data cnt busy
    add(idle(),                                            1, 0, 0, 0, 32'h0,        0, 32'h0);
    add(st(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0, 0),    1, 0, 1, 5, 32'hDEADBEEF, 0, 32'h0);
    add(st(1, 0, 32'h1111,     0, 0, 0, 0, 0, 0, 0, 0),    1, 0, 0, 5, 32'hDEADBEEF, 0, 32'h0);
    add(st(0, 0, 0, 0, 0, 0,          1, 7, 0, 0, 0),      1, 0, 0, 5, 32'hDEADBEEF, 0, 32'h80);
    add(st(0, 0, 0, 1, 7, 32'h12,     0, 0, 7, 0, 0),      1, 1, 1, 7, 32'h12,       0, 32'h0);
    add(st(0, 0, 0, 0, 0, 0,          0, 0, 7, 0, 0),      1, 0, 0, 7, 32'h12,       0, 32'h0);
    add(st(0, 0, 0, 0, 0, 0,          1, 9, 0, 0, 0),      1, 0, 0, 7, 32'h12,       0, 32'h200);
    add(st(0, 0, 0, 0, 0, 0,          0, 0, 0, 9, 0),      1, 1, 0, 7, 32'h12,       0, 32'h200);
    add(st(0, 0, 0, 0, 0, 0,          0, 0, 0, 0, 9),      1, 1, 0, 7, 32'h12,       0, 32'h200);
    add(st(0, 0, 0, 0, 0, 0,          0, 0, 0, 3, 0),      1, 0, 0, 7, 32'h12,       0, 32'h200);
    add(st(0, 0, 0, 1, 9, 32'h99,     1, 9, 0, 0, 0),      1, 0, 1, 9, 32'h99,       0, 32'h200);
    add(st(0, 0, 0, 0, 0, 0,          0, 0, 9, 0, 0),      1, 1, 0, 9, 32'h99,       0, 32'h200);
    add(st(0, 0, 0, 1, 9, 32'h98,     0, 0, 0, 0, 0),      1, 0, 1, 9, 32'h98,       0, 32'h0);
    add(st(0, 0, 0, 1, 0, 32'h55,     0, 0, 0, 0, 0),      1, 0, 0, 9, 32'h98,       0, 32'h0);
    add(st(1, 1, 32'hA1, 1, 3, 32'h33, 0, 0, 0, 0, 0),     1, 0, 1, 1, 32'hA1,       1, 32'h0);
    add(st(1, 1, 32'hB1, 1, 4, 32'h44, 0, 0, 0, 0, 0),     1, 0, 1, 1, 32'hB1,       2, 32'h0);
    add(st(1, 1, 32'hC1, 1, 5, 32'h55, 0, 0, 0, 0, 0),     0, 0, 1, 1, 32'hC1,       2, 32'h0);
    add(st(0, 0, 0,      1, 5, 32'h55, 0, 0, 0, 0, 0),     0, 0, 1, 3, 32'h33,       1, 32'h0);
    add(st(0, 0, 0,      1, 5, 32'h55, 0, 0, 0, 0, 0),     1, 0, 1, 4, 32'h44,       1, 32'h0);
    add(idle(),                                            1, 0, 1, 5, 32'h55,       0, 32'h0);
    add(idle(),                                            1, 0, 0, 5, 32'h55,       0, 32'h0);
    for (int i = 0; i < vt.size(); i++) step_tab(i, vt[i]);

    // ---------------- reset in the middle of traffic ----------------
    step_model("mid1", st(0, 0, 0,     0, 0,  0,        1, 10, 0, 0, 0));
    step_model("mid2", st(1, 1, 32'h1, 1, 10, 32'hA0,   1, 11, 0, 0, 0));
    step_model("mid3", st(1, 1, 32'h2, 1, 11, 32'hB0,   0, 0,  0, 0, 0));
    check("pre-reset fifo_count", bus.fifo_count, 2);
    check("pre-reset busy_mask", bus.busy_mask, 32'h0000_0C00);
    drive(st(0, 0, 0, 0, 0, 0, 0, 0, 10, 11, 0));
    #2;
    reset = 1'b0;
    #1;
    check("async reset rf_regwrite", bus.rf_regwrite, 0);
    check("async reset rf_rd", bus.rf_rd, 0);
    check("async reset rf_write_data", bus.rf_write_data, 0);
    check("async reset fifo_count", bus.fifo_count, 0);
    check("async reset busy_mask", bus.busy_mask, 0);
    check("async reset mc_ready", bus.mc_ready, 1);
    check("async reset stall", bus.stall, 0);
    @(posedge clk);
    #2;
    reset = 1'b1;
    reset_model();
    for (int i = 0; i < 3; i++) begin
      step_model($sformatf("post-reset%0d", i), idle());
      check($sformatf("no stale write %0d", i), bus.rf_regwrite, 0);
    end

    // ---------------- random traffic against the model ----------------
    hold = 1'b0;
    last = idle();
    for (int i = 0; i < 600; i++) begin
      s = idle();
      s.wb_we   = ($urandom_range(0, 9) < 4);
      s.wb_rd   = 5'($urandom_range(0, 31));
      s.wb_data = $urandom;
      if (hold) begin
        s.mc_valid = 1'b1;
        s.mc_rd    = last.mc_rd;
        s.mc_data  = last.mc_data;
      end else begin
        s.mc_valid = ($urandom_range(0, 9) < 5);
        s.mc_rd    = ($urandom_range(0, 1) == 1) ? pick_busy() : 5'($urandom_range(0, 31));
        s.mc_data  = $urandom;
      end
      if ($urandom_range(0, 9) < 3) begin
        r = 5'($urandom_range(1, 31));
        if (!m_busy[r]) begin
          s.iss    = 1'b1;
          s.iss_rd = r;
        end
      end
      s.rs1 = ($urandom_range(0, 1) == 1) ? pick_busy() : 5'($urandom_range(0, 31));
      s.rs2 = 5'($urandom_range(0, 31));
      s.rd  = 5'($urandom_range(0, 31));
      hold = s.mc_valid && (mq.size() == DEPTH);
      step_model($sformatf("rnd%0d", i), s);
      last = s;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
